ahbl_rr_slave_arbiter4: RTL and testbench
=========================================

AHBL_RR_SLAVE_ARBITER4 -- requirements
Module: ahbl_rr_slave_arbiter4

Interface
REQ-001 Parameter HOLD_MAX, default 8: maximum consecutive granted beats for one unlocked master before forced re-arbitration; legal range 2..255.
REQ-002 HCLK  input  1  clock; all state updates on rising edge.
REQ-003 HRESETN  input  1  reset, asynchronous, active-low.
REQ-004 MREQ  input  4  bit m=1: master m drives NONSEQ/SEQ to this slave in the current cycle.
REQ-005 MSEQ  input  4  bit m=1: master m's HTRANS is SEQ (burst continuation).
REQ-006 MLOCK  input  4  bit m=1: master m asserts HMASTLOCK.
REQ-007 HREADYOUT  input  1  slave ready; a transfer advances only when 1.
REQ-008 ADDRSEL  output  4  one-hot or zero, combinational; selects the master whose address phase is routed to the slave.
REQ-009 DATASEL  output  4  one-hot or zero, registered; selects the master whose data phase is routed to the slave and receives HREADY/HRESP.
REQ-010 OWNER  output  2  index of the current address-phase owner, registered.

Function
REQ-011 FSM states: IDLE (no owner), OWN (unlocked owner), LOCK (locked owner).
REQ-012 Arbitration point exists only when HREADYOUT=1 and one of: state IDLE; owner MREQ=0; owner MSEQ=0 in OWN; beat count = HOLD_MAX in OWN.
REQ-013 At an arbitration point, the winner is the first requesting master searching from (last_winner+1) mod 4 upward with wrap; last_winner resets to 3, so master 0 has first priority.
REQ-014 At an arbitration point, ADDRSEL = one-hot winner in the same cycle; with no requester, ADDRSEL=0 and next state IDLE.
REQ-015 Outside arbitration points, ADDRSEL = one-hot OWNER when owner MREQ=1, else 0.
REQ-016 Winner with MLOCK=1 -> next state LOCK; winner with MLOCK=0 -> OWN; last_winner and OWNER update on the same edge.
REQ-017 LOCK is exited only when owner MLOCK=0 and HREADYOUT=1; the hold limit and MSEQ are ignored in LOCK.
REQ-018 The beat counter is 8 bits; it clears to 1 on every grant and increments on each HREADYOUT=1 cycle with owner MREQ=1; it saturates at HOLD_MAX.
REQ-019 A hold-limit break while the owner asserts SEQ is permitted; the owner re-requests and competes in round-robin order.
REQ-020 On HREADYOUT=1 edges, DATASEL <= ADDRSEL; on HREADYOUT=0 edges, DATASEL holds, so a waited data phase keeps its master.
REQ-021 ADDRSEL and OWNER do not change while HREADYOUT=0, including when new requests arrive.
REQ-022 Simultaneous requests from all four masters with no locks -> grants rotate 0,1,2,3,0 at successive arbitration points.
REQ-023 ADDRSEL and DATASEL are never multi-hot.

Reset
REQ-024 While HRESETN=0: state IDLE, OWNER=0, last_winner=3, beat count=0, DATASEL=0; ADDRSEL follows REQ-014 from IDLE.
REQ-025 Reset asserted mid-burst or mid-lock aborts ownership immediately; the first grant after release follows REQ-013 from last_winner=3.

Structure
REQ-026 Shared package ahbl_arb_pkg holds NUM_MASTERS=4, the state-encoding constants, and the one-hot select constants.
REQ-027 Round-robin selection is implemented as sub-module ahbl_rr_pick4 (inputs: request vector, last_winner; outputs: valid, index); it is purely combinational.
REQ-028 All other logic is in the top module with a single asynchronous-reset register process.

Verification
REQ-029 MREQ=0001 for 3 beats, HREADYOUT=1 -> ADDRSEL=0001 in the same cycle as each request; DATASEL=0001 one cycle later; returns to 0 after the burst.
REQ-030 MREQ=1111, MSEQ=0, MLOCK=0, HREADYOUT=1 for 8 cycles -> ADDRSEL sequence 0001,0010,0100,1000,0001,...
REQ-031 HOLD_MAX=4; master 1 SEQ burst of 8 beats with master 2 requesting -> master 2 is granted after beat 4; master 1 resumes after master 2's single transfer.
REQ-032 Master 0 MLOCK=1 for 12 beats, others requesting, HOLD_MAX=4 -> ADDRSEL=0001 throughout; master 1 is granted on the first ready cycle after MLOCK falls.
REQ-033 HREADYOUT=0 for 3 cycles during master 3's data phase while master 0 requests -> DATASEL=1000 and ADDRSEL frozen for 3 cycles; switch occurs on the ready edge.
REQ-034 HRESETN pulsed low mid-lock of master 2 -> DATASEL=0, OWNER=0, state IDLE asynchronously; with MREQ=0110 after release, master 1 is granted first.

Source files
------------

// File: rtl/ahbl_arb_pkg.sv
// Shared types and constants for the 4-master AHB-Lite slave-side arbiter.
package ahbl_arb_pkg;

  localparam int unsigned NUM_MASTERS = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn  = 2'd1,
    StLock = 2'd2
  } arb_state_e;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_M0   = 4'b0001;
  localparam logic [3:0] SEL_M1   = 4'b0010;
  localparam logic [3:0] SEL_M2   = 4'b0100;
  localparam logic [3:0] SEL_M3   = 4'b1000;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] sel;
    unique case (idx)
      2'd0:    sel = SEL_M0;
      2'd1:    sel = SEL_M1;
      2'd2:    sel = SEL_M2;
      default: sel = SEL_M3;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/ahbl_rr_pick4.sv
// Combinational round-robin picker: first requester after last_winner, with wrap.
module ahbl_rr_pick4
  import ahbl_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [1:0]             last_winner,
  output logic                   valid,
  output logic [1:0]             index
);

  always_comb begin
    valid = 1'b0;
    index = 2'd0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      logic [1:0] cand;
      cand = last_winner + 2'(i);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/ahbl_rr_slave_arbiter4.sv
// Slave-side round-robin arbiter for four AHB-Lite masters with HMASTLOCK and a
// per-owner beat limit; address select is combinational, data select registered.
module ahbl_rr_slave_arbiter4
  import ahbl_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       HCLK,
  input  logic       HRESETN,
  input  logic [3:0] MREQ,
  input  logic [3:0] MSEQ,
  input  logic [3:0] MLOCK,
  input  logic       HREADYOUT,
  output logic [3:0] ADDRSEL,
  output logic [3:0] DATASEL,
  output logic [1:0] OWNER
);

  localparam logic [7:0] HoldMax = 8'(HOLD_MAX);

  arb_state_e state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] datasel_q;
  logic       win_valid;
  logic [1:0] win_idx;
  logic       own_req;
  logic       arb_point;

  ahbl_rr_pick4 u_pick (
    .req        (MREQ),
    .last_winner(last_q),
    .valid      (win_valid),
    .index      (win_idx)
  );

  assign own_req = MREQ[owner_q];

  // Nothing moves while the slave stalls, so every arbitration point needs HREADYOUT.
  always_comb begin
    arb_point = 1'b0;
    if (HREADYOUT) begin
      unique case (state_q)
        StIdle:  arb_point = 1'b1;
        StOwn:   arb_point = !own_req || !MSEQ[owner_q] || (cnt_q == HoldMax);
        StLock:  arb_point = !MLOCK[owner_q];
        default: arb_point = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ADDRSEL = (state_q != StIdle && own_req) ? onehot4(owner_q) : SEL_NONE;
    if (arb_point) begin
      if (win_valid) begin
        ADDRSEL = onehot4(win_idx);
        state_d = MLOCK[win_idx] ? StLock : StOwn;
        owner_d = win_idx;
        last_d  = win_idx;
        cnt_d   = 8'd1;
      end else begin
        ADDRSEL = SEL_NONE;
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    end else if (HREADYOUT && state_q != StIdle && own_req && cnt_q < HoldMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state_q   <= StIdle;
      owner_q   <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= 8'd0;
      datasel_q <= SEL_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      if (HREADYOUT) datasel_q <= ADDRSEL;
    end
  end

  assign DATASEL = datasel_q;
  assign OWNER   = owner_q;

endmodule

// File: tb/tb_ahbl_rr_slave_arbiter4.sv
// Directed bench for ahbl_rr_slave_arbiter4 (HOLD_MAX=4) with hand-computed selects.
module tb_ahbl_rr_slave_arbiter4;

  logic       HCLK = 1'b0;
  logic       HRESETN = 1'b0;
  logic [3:0] MREQ = '0, MSEQ = '0, MLOCK = '0;
  logic       HREADYOUT = 1'b1;
  logic [3:0] ADDRSEL, DATASEL;
  logic [1:0] OWNER;

  int n_checks = 0;
  int n_errors = 0;

  ahbl_rr_slave_arbiter4 #(.HOLD_MAX(4)) dut (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .MREQ     (MREQ),
    .MSEQ     (MSEQ),
    .MLOCK    (MLOCK),
    .HREADYOUT(HREADYOUT),
    .ADDRSEL  (ADDRSEL),
    .DATASEL  (DATASEL),
    .OWNER    (OWNER)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", tag, obs, exp);
    end
  endtask

  // Drive one cycle just after posedge, check at negedge, return just after next posedge.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] seq,
                      input logic [3:0] lock, input logic rdy,
                      input logic [3:0] exp_addr, input logic [3:0] exp_data);
    MREQ = req; MSEQ = seq; MLOCK = lock; HREADYOUT = rdy;
    @(negedge HCLK);
    check({tag, "/addrsel"}, ADDRSEL, exp_addr);
    check({tag, "/datasel"}, DATASEL, exp_data);
    @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset(input string tag);
    HRESETN = 1'b0;
    MREQ = '0; MSEQ = '0; MLOCK = '0; HREADYOUT = 1'b1;
    @(negedge HCLK);
    check({tag, "/rst_addrsel"}, ADDRSEL, 4'b0000);
    check({tag, "/rst_datasel"}, DATASEL, 4'b0000);
    check({tag, "/rst_owner"}, {2'b00, OWNER}, 4'd0);
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
  endtask

  logic [3:0] rot_addr [8];
  logic [3:0] rot_data [8];

  initial begin
    rot_addr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rot_data = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    @(posedge HCLK);
    #1;

    // Single master burst of three beats
    do_reset("burst");
    step("burst_b1", 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000);
    step("burst_b2", 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001);
    step("burst_b3", 4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001);
    step("burst_end", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001);
    step("burst_idle", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);

    // All four requesting NONSEQ: pure rotation
    do_reset("rot");
    for (int i = 0; i < 8; i++)
      step($sformatf("rot%0d", i), 4'b1111, 4'b0000, 4'b0000, 1'b1, rot_addr[i], rot_data[i]);

    // Hold limit: master 1 SEQ burst preempted after 4 beats by master 2
    do_reset("hold");
    step("hold_g1", 4'b0110, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000);
    step("hold_b2", 4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010);
    step("hold_b3", 4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010);
    step("hold_b4", 4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010);
    step("hold_m2", 4'b0110, 4'b0010, 4'b0000, 1'b1, 4'b0100, 4'b0010);
    step("hold_m1", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0100);
    step("hold_m1b", 4'b0010, 4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010);

    // Locked master 0 ignores the hold limit; master 1 wins once the lock drops
    do_reset("lock");
    step("lock_g", 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0000);
    for (int i = 1; i < 12; i++)
      step($sformatf("lock%0d", i), 4'b1111, 4'b0000, 4'b0001, 1'b1, 4'b0001, 4'b0001);
    step("lock_fall_wait", 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0001);
    step("lock_rel", 4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0001);

    // Wait states during master 3's data phase freeze both selects
    do_reset("wait");
    step("wait_g3", 4'b1000, 4'b0000, 4'b0000, 1'b1, 4'b1000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("wait%0d", i), 4'b1001, 4'b0000, 4'b0000, 1'b0, 4'b1000, 4'b1000);
      check($sformatf("wait%0d/owner", i), {2'b00, OWNER}, 4'd3);
    end
    step("wait_sw", 4'b1001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b1000);
    check("wait_sw/owner", {2'b00, OWNER}, 4'd0);
    step("wait_done", 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001);

    // Asynchronous reset in the middle of master 2's lock
    do_reset("areset");
    step("ar_g2", 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 4'b0000);
    step("ar_l2", 4'b0100, 4'b0000, 4'b0100, 1'b1, 4'b0100, 4'b0100);
    check("ar_owner_pre", {2'b00, OWNER}, 4'd2);
    MREQ = 4'b0110; MLOCK = 4'b0000;
    #2;
    HRESETN = 1'b0;
    #1;
    check("ar_datasel", DATASEL, 4'b0000);
    check("ar_owner", {2'b00, OWNER}, 4'd0);
    check("ar_addrsel", ADDRSEL, 4'b0010);
    @(posedge HCLK);
    #1;
    HRESETN = 1'b1;
    step("ar_first", 4'b0110, 4'b0000, 4'b0000, 1'b1, 4'b0010, 4'b0000);
    step("ar_second", 4'b0110, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
